irq_ack_dispatch: RTL and testbench
===================================

IRQ_ACK_DISPATCH -- requirements
Module: irq_ack_dispatch

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15: max cycles an ack is held waiting for its request to drop (1..255).
REQ-002 SHALL provide parameter HOLDOFF, default 2: idle cycles after each ack before the next grant is accepted (0..15).
REQ-003 SHALL use one clock and an asynchronous, active-high reset:
  clk          in   1  single clock, rising edge
  rst          in   1  asynchronous, active-high reset
  grant_valid  in   1  encoder presents a winning channel
  grant_ready  out  1  dispatcher accepts a grant this cycle
  grant_bus    in   2  winning bus: 0=A, 1=B, 2=C, 3=none
  grant_chan   in   4  winning channel index, 0..8
  req_a        in   9  live request lines, bus A
  req_b        in   9  live request lines, bus B
  req_c        in   9  live request lines, bus C
  ack_a        out  9  one-hot acknowledge, bus A
  ack_b        out  9  one-hot acknowledge, bus B
  ack_c        out  9  one-hot acknowledge, bus C
  busy         out  1  state != IDLE
  err_invalid  out  1  one-cycle pulse: bad grant code
  err_timeout  out  1  one-cycle pulse: request failed to drop
  serviced     out  8  completed-ack count, wraps 255->0

Function
REQ-004 SHALL implement states IDLE, ACK and HOLD; grant_ready = 1 only in IDLE.
REQ-005 SHALL accept a grant on the edge where grant_valid && grant_ready, registering grant_bus and grant_chan.
REQ-006 A grant with grant_bus = 3 or grant_chan > 8 SHALL produce a one-cycle err_invalid pulse in the next cycle, assert no ack, and stay in IDLE.
REQ-007 A valid grant SHALL move the block to ACK and assert exactly one ack bit (bus, chan) from the next cycle; latency from acceptance to ack is 1 cycle.
REQ-008 All ack outputs SHALL be registered, with at most one of the 27 bits set in any cycle.
REQ-009 In ACK, when the addressed req bit is sampled 0, the block SHALL clear ack on that edge, increment serviced, and enter HOLD.
REQ-010 If the req bit is already 0 on the first ACK cycle, ack SHALL last exactly one cycle; this is not an error.
REQ-011 In ACK, a cycle counter SHALL start at 1; if it reaches TIMEOUT with req still 1, the block SHALL clear ack, pulse err_timeout for one cycle, leave serviced unchanged, and enter HOLD.
REQ-012 HOLD SHALL last HOLDOFF cycles and then return to IDLE; with HOLDOFF = 0 the block SHALL go from ACK directly to IDLE.
REQ-013 Request changes on lines other than the addressed one SHALL have no effect while in ACK or HOLD.
REQ-014 grant_valid while not ready SHALL be ignored; nothing is queued.
REQ-015 If req drops on the same cycle the counter reaches TIMEOUT, the drop SHALL win: count as serviced, no error.

Reset
REQ-016 While rst = 1: state = IDLE, all ack bits = 0, busy = 0, err_invalid = 0, err_timeout = 0, serviced = 0, all counters = 0.
REQ-017 grant_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-018 Reset asserted mid-ACK SHALL clear ack asynchronously and drop any registered grant.

Structure
REQ-019 A shared package c432_pkg SHALL hold NUM_CH = 9, the bus encoding enum (BUS_A, BUS_B, BUS_C, BUS_NONE) and the state enum.
REQ-020 The (bus, chan) to 27-bit one-hot decode SHALL be a separate combinational sub-module, ack_onehot_dec; all sequential logic stays in irq_ack_dispatch.

Verification
REQ-021 Grant bus = 1, chan = 5, req_b[5] = 1 for 4 cycles then 0 -> ack_b = 9'h020 from cycle +1 until the drop, serviced = 1, HOLD 2 cycles, grant_ready = 1 at the following edge.
REQ-022 Grant bus = 3, chan = 0 -> err_invalid = 1 for one cycle, no ack, grant_ready stays 1; repeat with bus = 0, chan = 12 -> same response.
REQ-023 Grant bus = 2, chan = 8 with req_c[8] held high -> ack_c = 9'h100 for 15 cycles, err_timeout pulse, serviced unchanged.
REQ-024 Grant bus = 0, chan = 0 with req_a[0] = 0 -> ack_a = 9'h001 for exactly one cycle, serviced + 1, no error.
REQ-025 rst asserted during ack_a[3] -> ack cleared immediately, serviced = 0, IDLE after release; with HOLDOFF = 0, back-to-back grants accepted two cycles apart.
REQ-026 Preload serviced = 255, complete one ack -> serviced = 0; grant_valid during HOLD -> ignored.

Source files
------------

// File: rtl/irq_ack_dispatch_pkg.sv
// Shared types for the IRQ acknowledge dispatcher: channel count, bus codes,
// FSM states and the packed 27-bit acknowledge vector.
package c432_pkg;

    localparam int unsigned NUM_CH = 9;

    typedef enum logic [1:0] {
        BUS_A    = 2'd0,
        BUS_B    = 2'd1,
        BUS_C    = 2'd2,
        BUS_NONE = 2'd3
    } bus_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Bus C occupies the top nine bits, bus A the bottom nine.
    typedef struct packed {
        logic [NUM_CH-1:0] c;
        logic [NUM_CH-1:0] b;
        logic [NUM_CH-1:0] a;
    } ack_t;

    // A grant is usable only when it names a real bus and an existing channel.
    function automatic logic grant_ok(input bus_e bus, input logic [3:0] chan);
        return (bus != BUS_NONE) && (chan < 4'(NUM_CH));
    endfunction

endpackage

// File: rtl/irq_ack_dispatch_if.sv
// Grant handshake plus live request / acknowledge lines between the
// priority encoder side (master) and the dispatcher (slave).
interface irq_ack_dispatch_if;
    import c432_pkg::*;

    logic              grant_valid;
    logic              grant_ready;
    logic [1:0]        grant_bus;
    logic [3:0]        grant_chan;
    logic [NUM_CH-1:0] req_a;
    logic [NUM_CH-1:0] req_b;
    logic [NUM_CH-1:0] req_c;
    logic [NUM_CH-1:0] ack_a;
    logic [NUM_CH-1:0] ack_b;
    logic [NUM_CH-1:0] ack_c;

    modport master (
        output grant_valid, grant_bus, grant_chan, req_a, req_b, req_c,
        input  grant_ready, ack_a, ack_b, ack_c
    );

    modport slave (
        input  grant_valid, grant_bus, grant_chan, req_a, req_b, req_c,
        output grant_ready, ack_a, ack_b, ack_c
    );

endinterface

// File: rtl/irq_ack_dispatch_dec.sv
// Combinational (bus, chan) -> one-hot acknowledge decode. Illegal codes
// decode to all zeros with hit low.
module ack_onehot_dec
    import c432_pkg::*;
(
    input  logic [1:0]        bus,
    input  logic [3:0]        chan,
    output logic [NUM_CH-1:0] ack_a,
    output logic [NUM_CH-1:0] ack_b,
    output logic [NUM_CH-1:0] ack_c,
    output logic              hit
);

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    logic [NUM_CH-1:0] line;

    // Select the channel bit, then steer it onto the addressed bus only.
    always_comb begin
        ack_a = '0;
        ack_b = '0;
        ack_c = '0;
        hit   = grant_ok(bus_e'(bus), chan);
        line  = hit ? (ONE << chan) : '0;
        case (bus_e'(bus))
            BUS_A:   ack_a = line;
            BUS_B:   ack_b = line;
            BUS_C:   ack_c = line;
            default: ;
        endcase
    end

endmodule

// File: rtl/irq_ack_dispatch.sv
// Interrupt acknowledge dispatcher: accepts one grant at a time, holds a
// single registered ack until the addressed request drops or a timeout
// expires, then observes a hold-off gap before accepting the next grant.
module irq_ack_dispatch
    import c432_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic                clk,
    input  logic                rst,
    irq_ack_dispatch_if.slave   dsp_if,
    output logic                busy,
    output logic                err_invalid,
    output logic                err_timeout,
    output logic [7:0]          serviced
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [3:0] HOLD_W    = 4'(HOLDOFF);

    state_e            state_q, state_d;
    bus_e              bus_q, bus_d;
    logic [3:0]        chan_q, chan_d;
    ack_t              ack_q, ack_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        hold_q, hold_d;
    logic              err_inv_q, err_inv_d;
    logic              err_to_q, err_to_d;
    logic [7:0]        svc_q, svc_d;

    logic [NUM_CH-1:0] dec_a, dec_b, dec_c;
    logic              dec_hit;
    logic [NUM_CH-1:0] req_line;
    logic              req_hit;

    ack_onehot_dec u_dec (
        .bus   (dsp_if.grant_bus),
        .chan  (dsp_if.grant_chan),
        .ack_a (dec_a),
        .ack_b (dec_b),
        .ack_c (dec_c),
        .hit   (dec_hit)
    );

    // Pick the single request line addressed by the registered grant.
    always_comb begin
        req_line = '0;
        case (bus_q)
            BUS_A:   req_line = dsp_if.req_a;
            BUS_B:   req_line = dsp_if.req_b;
            BUS_C:   req_line = dsp_if.req_c;
            default: req_line = '0;
        endcase
        req_hit = req_line[chan_q];
    end

    // Next-state and next-register values; a request drop takes priority
    // over a timeout landing on the same edge.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        chan_d    = chan_q;
        ack_d     = ack_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        err_inv_d = 1'b0;
        err_to_d  = 1'b0;
        svc_d     = svc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dsp_if.grant_valid) begin
                    if (dec_hit) begin
                        state_d = ST_ACK;
                        bus_d   = bus_e'(dsp_if.grant_bus);
                        chan_d  = dsp_if.grant_chan;
                        ack_d   = '{c: dec_c, b: dec_b, a: dec_a};
                        cnt_d   = 8'd1;
                    end else begin
                        err_inv_d = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!req_hit || (cnt_q == TIMEOUT_W)) begin
                    ack_d = '0;
                    cnt_d = '0;
                    if (!req_hit) begin
                        svc_d = svc_q + 8'd1;
                    end else begin
                        err_to_d = 1'b1;
                    end
                    if (HOLD_W == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_W;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (hold_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, ack, counter, error-pulse and serviced-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q     <= BUS_A;
            chan_q    <= '0;
            ack_q     <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            err_inv_q <= 1'b0;
            err_to_q  <= 1'b0;
            svc_q     <= '0;
        end else begin
            bus_q     <= bus_d;
            chan_q    <= chan_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            err_inv_q <= err_inv_d;
            err_to_q  <= err_to_d;
            svc_q     <= svc_d;
        end
    end

    assign dsp_if.grant_ready = (state_q == ST_IDLE);
    assign dsp_if.ack_a       = ack_q.a;
    assign dsp_if.ack_b       = ack_q.b;
    assign dsp_if.ack_c       = ack_q.c;
    assign busy               = (state_q != ST_IDLE);
    assign err_invalid        = err_inv_q;
    assign err_timeout        = err_to_q;
    assign serviced           = svc_q;

endmodule

// File: tb/tb_irq_ack_dispatch.sv
// Scoreboard bench for irq_ack_dispatch: stimulus pushes expected ack /
// error events, a negedge monitor pops and compares them as they appear.
module tb_irq_ack_dispatch;
    import c432_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_ack_dispatch_if m_if ();
    irq_ack_dispatch_if z_if ();

    logic       busy, err_invalid, err_timeout;
    logic [7:0] serviced;
    logic       z_busy, z_err_invalid, z_err_timeout;
    logic [7:0] z_serviced;

    irq_ack_dispatch #(.TIMEOUT(15), .HOLDOFF(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .dsp_if      (m_if),
        .busy        (busy),
        .err_invalid (err_invalid),
        .err_timeout (err_timeout),
        .serviced    (serviced)
    );

    irq_ack_dispatch #(.TIMEOUT(4), .HOLDOFF(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .dsp_if      (z_if),
        .busy        (z_busy),
        .err_invalid (z_err_invalid),
        .err_timeout (z_err_timeout),
        .serviced    (z_serviced)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endfunction

    typedef struct {
        bit          inv;
        logic [26:0] ack;
        int unsigned len;
        bit          to;
        logic [7:0]  svc;
    } exp_t;

    exp_t sb[$];

    function automatic void push_ack(int unsigned b, int unsigned c, int unsigned len,
                                     bit to, logic [7:0] svc);
        exp_t e;
        logic [26:0] v;
        v = '0;
        v[b*9+c] = 1'b1;
        e.inv = 1'b0; e.ack = v; e.len = len; e.to = to; e.svc = svc;
        sb.push_back(e);
    endfunction

    function automatic void push_inv();
        exp_t e;
        e.inv = 1'b1; e.ack = '0; e.len = 0; e.to = 1'b0; e.svc = '0;
        sb.push_back(e);
    endfunction

    // Monitor: turns ack windows and err_invalid pulses into events.
    logic [26:0] mon_ack;
    logic [26:0] cur;
    bit          mon_in = 1'b0;
    bit          mon_chg;
    int unsigned mon_len;
    exp_t        me;

    always @(negedge clk) begin
        cur = {m_if.ack_c, m_if.ack_b, m_if.ack_a};
        if (rst) begin
            mon_in = 1'b0;
        end else begin
            if (err_invalid) begin
                if (sb.size() == 0) check("unexpected_err_invalid", 32'(err_invalid), 0);
                else begin
                    me = sb.pop_front();
                    check("event_kind_inv", 1, 32'(me.inv));
                    check("inv_no_ack", 32'(cur), 0);
                end
            end
            if (cur != '0) begin
                if (!mon_in) begin
                    mon_in = 1'b1; mon_len = 1; mon_ack = cur; mon_chg = 1'b0;
                end else begin
                    mon_len++;
                    if (cur != mon_ack) mon_chg = 1'b1;
                end
            end else if (mon_in) begin
                mon_in = 1'b0;
                if (sb.size() == 0) check("unexpected_ack", 32'(mon_ack), 0);
                else begin
                    me = sb.pop_front();
                    check("event_kind_ack", 0, 32'(me.inv));
                    check("ack_vec", 32'(mon_ack), 32'(me.ack));
                    check("ack_len", mon_len, me.len);
                    check("ack_stable", 32'(mon_chg), 0);
                    check("err_timeout", 32'(err_timeout), 32'(me.to));
                    check("serviced", 32'(serviced), 32'(me.svc));
                end
            end else if (err_timeout) begin
                check("stray_err_timeout", 32'(err_timeout), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input logic [1:0] b, input logic [3:0] c);
        m_if.grant_valid = 1'b1;
        m_if.grant_bus   = b;
        m_if.grant_chan  = c;
        tick();
        m_if.grant_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0]  exp_svc;
    int unsigned zl;
    bit          done;

    initial begin
        m_if.grant_valid = 1'b0; m_if.grant_bus = '0; m_if.grant_chan = '0;
        m_if.req_a = '0; m_if.req_b = '0; m_if.req_c = '0;
        z_if.grant_valid = 1'b0; z_if.grant_bus = '0; z_if.grant_chan = '0;
        z_if.req_a = '0; z_if.req_b = '0; z_if.req_c = '0;
        exp_svc = '0;
        rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'({m_if.ack_c, m_if.ack_b, m_if.ack_a}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err_inv", 32'(err_invalid), 0);
        check("rst_err_to", 32'(err_timeout), 0);
        check("rst_serviced", 32'(serviced), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(m_if.grant_ready), 1);
        tick();

        // bus B chan 5: request held for four samples, then dropped
        m_if.req_b[5] = 1'b1;
        grant(2'd1, 4'd5);
        exp_svc++;
        push_ack(1, 5, 5, 1'b0, exp_svc);
        @(negedge clk);
        check("b5_ack_b", 32'(m_if.ack_b), 32'h020);
        check("b5_busy", 32'(busy), 1);
        check("b5_ready", 32'(m_if.grant_ready), 0);
        repeat (4) tick();
        m_if.req_b[5] = 1'b0;
        tick();
        // in HOLD: a grant offered now must be ignored
        m_if.req_a[1] = 1'b1;
        m_if.grant_valid = 1'b1; m_if.grant_bus = 2'd0; m_if.grant_chan = 4'd1;
        @(negedge clk);
        check("hold1_ready", 32'(m_if.grant_ready), 0);
        check("hold1_busy", 32'(busy), 1);
        tick();
        @(negedge clk);
        check("hold2_ready", 32'(m_if.grant_ready), 0);
        tick();
        m_if.grant_valid = 1'b0;
        @(negedge clk);
        check("post_hold_ready", 32'(m_if.grant_ready), 1);
        check("post_hold_busy", 32'(busy), 0);
        repeat (2) tick();
        check("hold_grant_ignored", 32'(m_if.ack_a), 0);
        m_if.req_a[1] = 1'b0;

        // invalid bus code, then out-of-range channel
        grant(2'd3, 4'd0);
        push_inv();
        @(negedge clk);
        check("inv1_ready", 32'(m_if.grant_ready), 1);
        tick();
        @(negedge clk);
        check("inv1_one_cycle", 32'(err_invalid), 0);
        grant(2'd0, 4'd12);
        push_inv();
        @(negedge clk);
        check("inv2_ready", 32'(m_if.grant_ready), 1);
        tick();
        @(negedge clk);
        check("inv2_one_cycle", 32'(err_invalid), 0);
        tick();

        // bus C chan 8 held high: timeout after 15 ack cycles, other lines toggle
        m_if.req_c[8] = 1'b1;
        grant(2'd2, 4'd8);
        push_ack(2, 8, 15, 1'b1, exp_svc);
        for (int k = 0; k < 20; k++) begin
            m_if.req_a = (k % 2 == 1) ? 9'h1FF : 9'h000;
            m_if.req_b = (k % 2 == 0) ? 9'h1FF : 9'h000;
            m_if.req_c[7:0] = (k % 3 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        m_if.req_a = '0; m_if.req_b = '0; m_if.req_c = '0;
        tick();

        // bus A chan 0 with request already low: single-cycle ack
        grant(2'd0, 4'd0);
        exp_svc++;
        push_ack(0, 0, 1, 1'b0, exp_svc);
        repeat (4) tick();

        // drop coincides with counter reaching TIMEOUT: drop wins
        m_if.req_a[2] = 1'b1;
        grant(2'd0, 4'd2);
        exp_svc++;
        push_ack(0, 2, 15, 1'b0, exp_svc);
        repeat (14) tick();
        m_if.req_a[2] = 1'b0;
        repeat (4) tick();

        // reset asserted during ack_a[3]
        m_if.req_a[3] = 1'b1;
        grant(2'd0, 4'd3);
        repeat (2) tick();
        @(negedge clk);
        check("pre_rst_ack_a", 32'(m_if.ack_a), 32'h008);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_async_ack", 32'({m_if.ack_c, m_if.ack_b, m_if.ack_a}), 0);
        check("rst_async_svc", 32'(serviced), 0);
        check("rst_async_busy", 32'(busy), 0);
        exp_svc = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.req_a[3] = 1'b0;
        @(negedge clk);
        check("rel_busy", 32'(busy), 0);
        check("rel_ready", 32'(m_if.grant_ready), 1);
        check("rel_ack", 32'({m_if.ack_c, m_if.ack_b, m_if.ack_a}), 0);
        tick();

        // serviced count wraps 255 -> 0
        for (int i = 0; i < 256; i++) begin
            grant(2'd0, 4'd0);
            exp_svc++;
            push_ack(0, 0, 1, 1'b0, exp_svc);
            repeat (3) tick();
        end
        check("svc_wrap", 32'(serviced), 0);

        // HOLDOFF = 0 instance: back-to-back grants two cycles apart
        z_if.grant_valid = 1'b1; z_if.grant_bus = 2'd1; z_if.grant_chan = 4'd2;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("z_b2b_ack", 32'(z_if.ack_b), (k % 2 == 0) ? 32'h004 : 32'h0);
            check("z_b2b_svc", 32'(z_serviced), 32'((k + 1) / 2));
            check("z_b2b_ready", 32'(z_if.grant_ready), 32'(k % 2));
        end
        z_if.grant_valid = 1'b0;
        @(negedge clk);
        check("z_b2b_stop", 32'(z_if.ack_b), 0);

        // HOLDOFF = 0 instance: TIMEOUT = 4, straight back to IDLE
        tick();
        z_if.req_c[1] = 1'b1;
        z_if.grant_valid = 1'b1; z_if.grant_bus = 2'd2; z_if.grant_chan = 4'd1;
        tick();
        z_if.grant_valid = 1'b0;
        zl = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (z_if.ack_c == 9'h002) zl++;
            else begin
                done = 1'b1;
                check("z_to_len", zl, 4);
                check("z_to_err", 32'(z_err_timeout), 1);
                check("z_to_ready", 32'(z_if.grant_ready), 1);
                check("z_to_svc", 32'(z_serviced), 3);
            end
        end
        if (!done) check("z_to_bound", 32'(done), 1);
        z_if.req_c[1] = 1'b0;

        // let any outstanding expected events drain
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
